// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, data width and result entry layout for the logic unit path
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NOTA = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    // One buffered result: value, the op that made it, and flags frozen at capture
    typedef struct packed {
        logic [1:0]        ctrl;
        logic [DATA_W-1:0] s;
        logic              zero;
        logic              neg;
        logic              par;
    } entry_t;

endpackage

// File: rtl/alu_flags.sv
// rtl/alu_flags.sv - combinational zero/negative/parity status of a result word
import alu_pkg::*;

module alu_flags (
    input  logic [DATA_W-1:0] s,
    output logic              zero,
    output logic              neg,
    output logic              par
);

    // Flags are pure functions of the word so any later stage can reuse this block
    always_comb begin
        zero = (s == '0);
        neg  = s[DATA_W-1];
        par  = ^s;
    end

endmodule

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - FIFO of logic unit results with capture-time flags and valid/ready output
import alu_pkg::*;

module alu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_s,
    input  logic [1:0]        in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_s,
    output logic [1:0]        out_ctrl,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_par,
    output logic [CW-1:0]     count
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    entry_t          mem [DEPTH];
    entry_t          new_entry;
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            f_zero;
    logic            f_neg;
    logic            f_par;

    alu_flags u_flags (
        .s    (in_s),
        .zero (f_zero),
        .neg  (f_neg),
        .par  (f_par)
    );

    // Handshakes and the entry to capture; ready depends only on state so there is no full-time pass-through
    always_comb begin
        in_ready  = (count < DEPTH_C) & ~rst;
        out_valid = (count != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        new_entry = '{ctrl: in_ctrl, s: in_s, zero: f_zero, neg: f_neg, par: f_par};
    end

    // Head fields are forced to zero while empty so the consumer never sees stale data
    always_comb begin
        head      = out_valid ? mem[rd_ptr] : '0;
        out_s     = head.s;
        out_ctrl  = head.ctrl;
        out_zero  = head.zero;
        out_neg   = head.neg;
        out_par   = head.par;
    end

    // Storage needs no reset: nothing is visible until count says it was written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // Pointer and occupancy tracking; flush wins over any concurrent push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - directed self-checking bench for alu_result_buffer
module tb_alu_result_buffer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_s;
    logic [1:0] in_ctrl;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_s;
    logic [1:0] out_ctrl;
    logic       out_zero;
    logic       out_neg;
    logic       out_par;
    logic [2:0] count;

    int n_checks;
    int n_errors;

    alu_result_buffer #(.DEPTH(4), .CW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_ctrl  (out_ctrl),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_par   (out_par),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_one(input logic [7:0] v, input logic [1:0] c);
        in_valid = 1'b1;
        in_s     = v;
        in_ctrl  = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [7:0] v, input logic [1:0] c,
                              input logic z, input logic n, input logic p);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_s"},     out_s,     v);
        check({tag, "_ctrl"},  out_ctrl,  c);
        check({tag, "_zero"},  out_zero,  z);
        check({tag, "_neg"},   out_neg,   n);
        check({tag, "_par"},   out_par,   p);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_s      = 8'h00;
        in_ctrl   = 2'b00;
        flush     = 1'b0;
        out_ready = 1'b0;

        // reset state
        #1;
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_s", out_s, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);

        // empty pop from reset
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("empty_count", count, 0);
            check("empty_valid", out_valid, 0);
        end
        out_ready = 1'b0;

        // single transfer, held with out_ready low
        push_one(8'h80, 2'b11);
        check("single_count", count, 1);
        check_head("single", 8'h80, 2'b11, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_head("hold", 8'h80, 2'b11, 0, 1, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_drain_count", count, 0);
        check("single_drain_valid", out_valid, 0);
        check("single_drain_s", out_s, 0);

        // fill and block
        push_one(8'h00, 2'b00);
        push_one(8'h0F, 2'b01);
        push_one(8'hF0, 2'b10);
        push_one(8'hFF, 2'b11);
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_s     = 8'h55;
        in_ctrl  = 2'b01;
        tick();
        tick();
        check("blocked_count", count, 4);
        check_head("d0", 8'h00, 2'b00, 1, 0, 0);
        out_ready = 1'b1;
        tick();
        check("reassert_in_ready", in_ready, 1);
        check("after_pop_count", count, 3);
        check_head("d1", 8'h0F, 2'b01, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        check("pushpop_count", count, 3);
        check_head("d2", 8'hF0, 2'b10, 0, 1, 0);
        tick();
        check_head("d3", 8'hFF, 2'b11, 0, 1, 0);
        tick();
        check_head("d4", 8'h55, 2'b01, 0, 0, 0);
        tick();
        out_ready = 1'b0;
        check("drained_count", count, 0);

        // simultaneous push/pop at count 2, pointers wrap several laps
        push_one(8'h10, 2'b00);
        push_one(8'h11, 2'b01);
        check("pp_start_count", count, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] exp_v;
            logic [7:0] nv;
            exp_v    = 8'h10 + 8'(i);
            nv       = 8'h12 + 8'(i);
            in_valid = 1'b1;
            in_s     = nv;
            in_ctrl  = nv[1:0];
            check("pp_head_s", out_s, exp_v);
            check("pp_head_ctrl", out_ctrl, exp_v[1:0]);
            tick();
            check("pp_count", count, 2);
        end
        in_valid = 1'b0;
        check("pp_tail0", out_s, 8'h1A);
        tick();
        check("pp_tail1", out_s, 8'h1B);
        check("pp_tail1_ctrl", out_ctrl, 2'b11);
        tick();
        out_ready = 1'b0;
        check("pp_end_count", count, 0);

        // flush beats concurrent push and pop at count 3
        push_one(8'hA1, 2'b00);
        push_one(8'hA2, 2'b00);
        push_one(8'hA3, 2'b00);
        check("fl_pre_count", count, 3);
        in_valid  = 1'b1;
        in_s      = 8'hEE;
        in_ctrl   = 2'b10;
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        check("fl_in_ready", in_ready, 1);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("fl_count", count, 0);
        check("fl_valid", out_valid, 0);
        check("fl_out_s", out_s, 0);
        push_one(8'h3C, 2'b01);
        check_head("post_fl", 8'h3C, 2'b01, 0, 0, 0);
        check("post_fl_count", count, 1);
        do_reset();
        check("post_rst_count", count, 0);

        // asynchronous reset between edges with two entries loaded
        push_one(8'h81, 2'b10);
        push_one(8'h42, 2'b01);
        check("mid_pre_count", count, 2);
        #2;
        rst = 1'b1;
        #1;
        check("mid_count", count, 0);
        check("mid_valid", out_valid, 0);
        check("mid_out_s", out_s, 0);
        check("mid_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rel_in_ready", in_ready, 1);
        check("mid_rel_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
